// File: rtl/md_pkg.sv
// Shared definitions for the multicycle multiply/divide unit and its controller.
package md_pkg;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } md_state_t;

    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    localparam int MD_WIDTH   = 32;
    // Cycles from the accepted start to the done pulse; sizes the controller's wait.
    localparam int MD_LATENCY = MD_WIDTH + 2;

endpackage

// File: rtl/md_addsub.sv
// N-bit adder/subtractor with carry-out. On subtract, cout = 1 means x >= y.
module md_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] full;

    assign full = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{N{1'b0}}, sub};
    assign sum  = full[N-1:0];
    assign cout = full[N];

endmodule

// File: rtl/mult_div_unit.sv
// Signed multicycle multiply (shift-add) / divide (restoring) on operand magnitudes,
// one bit per cycle, followed by a single sign-correction cycle.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             MDCtrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             div0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_t          state;
    logic [CNT_W-1:0]   count;
    logic               op_div;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    logic               accept;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     add_y;
    logic [WIDTH:0]     add_sum;
    logic               add_cout;
    logic [WIDTH:0]     mult_step;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    assign div0   = MDCtrl & (b == '0);
    assign accept = start & ~div0 & ((state == MD_IDLE) || (state == MD_DONE));

    // Magnitude of the most-negative value is 2^(WIDTH-1), exact as unsigned.
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // MULT: acc_hi:acc_lo is the product/multiplier shift register.
    // DIV: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign add_x = op_div ? {acc_hi, acc_lo[WIDTH-1]} : {1'b0, acc_hi};
    assign add_y = {1'b0, opnd};

    md_addsub #(
        .N(WIDTH + 1)
    ) u_addsub (
        .x   (add_x),
        .y   (add_y),
        .sub (op_div),
        .sum (add_sum),
        .cout(add_cout)
    );

    assign mult_step = acc_lo[0] ? add_sum : add_x;

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = (sa ^ sb) ? -prod : prod;
    assign q_fix    = (sa ^ sb) ? -acc_lo : acc_lo;
    assign r_fix    = sa ? -acc_hi : acc_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= MD_IDLE;
            count  <= '0;
            op_div <= MD_MULT;
            sa     <= 1'b0;
            sb     <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                MD_IDLE, MD_DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        op_div <= MDCtrl;
                        sa     <= a[WIDTH-1];
                        sb     <= b[WIDTH-1];
                        opnd   <= (MDCtrl == MD_DIV) ? abs_b : abs_a;
                        acc_hi <= '0;
                        acc_lo <= (MDCtrl == MD_DIV) ? abs_a : abs_b;
                        count  <= CNT_W'(WIDTH);
                        busy   <= 1'b1;
                        state  <= MD_CALC;
                    end else begin
                        state  <= MD_IDLE;
                    end
                end
                MD_CALC: begin
                    if (op_div) begin
                        // Remainder stays below |b| <= 2^(WIDTH-1), so WIDTH bits hold it.
                        acc_hi <= add_cout ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], add_cout};
                    end else begin
                        acc_hi <= mult_step[WIDTH:1];
                        acc_lo <= {mult_step[0], acc_lo[WIDTH-1:1]};
                    end
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    if (op_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= MD_DONE;
                end
                default: begin
                    state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected hi/lo are queued at start and checked at done.
module tb_mult_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          MDCtrl = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          div0;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb_q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .MDCtrl(MDCtrl),
        .a     (a),
        .b     (b),
        .div0  (div0),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx;
        longint sy;
        longint p;
        longint q;
        longint r;
        exp_t   e;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op) begin
            q = sx / sy;
            r = sx % sy;
            e.hi = r[W-1:0];
            e.lo = q[W-1:0];
        end else begin
            p = sx * sy;
            e.hi = p[2*W-1:W];
            e.lo = p[W-1:0];
        end
        return e;
    endfunction

    // Pulse start for one cycle and queue the model result; returns in cycle 1.
    task automatic launch(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
        start  = 1'b1;
        MDCtrl = op;
        a      = x;
        b      = y;
        sb_q.push_back(model(op, x, y));
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input string name, input int start_cyc);
        int   cyc;
        int   busy_bad;
        bit   got;
        exp_t e;
        cyc = start_cyc;
        busy_bad = 0;
        got = 1'b0;
        while (cyc <= 60 && !got) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_bad++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        n_vec++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s timeout: no done within 60 cycles, required done at %0d", name, LAT);
            return;
        end
        n_vec++;
        if (cyc !== LAT) begin
            n_bad++;
            $display("FAIL %s latency: got %0d required %0d", name, cyc, LAT);
        end
        n_vec++;
        if (busy_bad !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy: %0d low cycles before done, busy at done=%b required 0", name, busy_bad, busy);
        end
        n_vec++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s scoreboard: done with empty queue", name);
            return;
        end
        e = sb_q.pop_front();
        if (hi !== e.hi || lo !== e.lo) begin
            n_bad++;
            $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, e.hi, e.lo);
        end
        last_hi = e.hi;
        last_lo = e.lo;
        $display("%s: done at cycle %0d hi=%h lo=%h", name, cyc, hi, lo);
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    endtask

    task automatic test_mult();
        launch(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done("mult_7_x_m3", 1);
        launch(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_min_x_min", 1);
        MDCtrl = 1'b0;
        a = 32'd123;
        b = '0;
        #1;
        n_vec++;
        if (div0 !== 1'b0) begin
            n_bad++;
            $display("FAIL mult_b0_div0: got %b required 0", div0);
        end
        launch(1'b0, 32'd123, 32'd0);
        wait_done("mult_b0", 1);
    endtask

    task automatic test_div();
        launch(1'b1, 32'd100, 32'd7);
        wait_done("div_100_7", 1);
        launch(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_m7_2", 1);
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_min_m1", 1);
        launch(1'b1, 32'h1234_5678, 32'hFFFF_FF00);
        wait_done("div_pos_neg", 1);
    endtask

    task automatic test_div0();
        int seen;
        start  = 1'b1;
        MDCtrl = 1'b1;
        a      = 32'd55;
        b      = '0;
        #1;
        n_vec++;
        if (div0 !== 1'b1) begin
            n_bad++;
            $display("FAIL div0_flag: got %b required 1", div0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b0 || done !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL div0_ignored: busy/done high in %0d cycles required 0", seen);
        end
        n_vec++;
        if (hi !== last_hi || lo !== last_lo) begin
            n_bad++;
            $display("FAIL div0_hold: hi=%h lo=%h required hi=%h lo=%h", hi, lo, last_hi, last_lo);
        end
        $display("div0: flag seen, hi=%h lo=%h held", hi, lo);
    endtask

    task automatic test_start_while_busy();
        launch(1'b0, 32'hFFFF_FF85, 32'd1000);
        repeat (9) begin
            @(posedge clk); #1;
        end
        start  = 1'b1;
        MDCtrl = 1'b1;
        a      = 32'd5;
        b      = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("mult_busy_start", 11);
    endtask

    task automatic test_back_to_back();
        launch(1'b1, 32'd1000, 32'hFFFF_FFFD);
        wait_done("b2b_first", 1);
        launch(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        wait_done("b2b_second", 1);
    endtask

    task automatic test_reset_midop();
        int seen;
        launch(1'b0, 32'd99, 32'd77);
        repeat (14) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_bad++;
            $display("FAIL reset_midop: busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
        end
        sb_q.delete();
        last_hi = '0;
        last_lo = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL reset_abandon: busy/done high in %0d cycles after reset required 0", seen);
        end
        $display("reset_midop: operation abandoned, hi=%h lo=%h", hi, lo);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midop();
        launch(1'b1, 32'd100, 32'd7);
        wait_done("div_after_reset", 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
